// File: rtl/enc4x2_reg.sv
// ============================================================================
// enc4x2_reg : registered 4-to-2 priority encoder with a 2-entry output FIFO
// Optional multi-hot detection enabled by macro ENC_ONEHOT_CHK_EN
// Revision   : 1.0
// ============================================================================
`default_nettype none

module enc4x2_reg (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       D3,
    input  logic       D2,
    input  logic       D1,
    input  logic       D0,
    input  logic       IN_VLD,
    output logic       IN_RDY,
    output logic       Y1,
    output logic       Y0,
    output logic       V,
    output logic       OUT_VLD,
    input  logic       OUT_RDY,
    output logic [7:0] CNT,
    output logic       ERR
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    // Entry layout: {Y1, Y0, V}
    logic [2:0] head_q, head_d;
    logic [2:0] tail_q, tail_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] enc;
    logic       push;
    logic       pop;

    always_comb begin
        enc = 3'b000;
        if (D3)      enc = 3'b111;
        else if (D2) enc = 3'b101;
        else if (D1) enc = 3'b011;
        else if (D0) enc = 3'b001;
    end

    // Ready is a pure function of state, never of OUT_RDY.
    assign IN_RDY  = (state_q != S_FULL);
    assign OUT_VLD = (state_q != S_EMPTY);
    assign push    = IN_VLD & IN_RDY;
    assign pop     = OUT_VLD & OUT_RDY;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (push) cnt_d = cnt_q + 8'd1;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_ONE;
                    head_d  = enc;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = enc;
                end else if (push) begin
                    state_d = S_FULL;
                    tail_d  = enc;
                end else if (pop) begin
                    state_d = S_EMPTY;
                    head_d  = 3'b000;
                end
            end
            S_FULL: begin
                if (pop) begin
                    state_d = S_ONE;
                    head_d  = tail_q;
                    tail_d  = 3'b000;
                end
            end
            default: begin
                state_d = S_EMPTY;
                head_d  = 3'b000;
                tail_d  = 3'b000;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_EMPTY;
            head_q  <= 3'b000;
            tail_q  <= 3'b000;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate with OUT_VLD so the outputs read zero whenever nothing is held.
    assign Y1  = head_q[2] & OUT_VLD;
    assign Y0  = head_q[1] & OUT_VLD;
    assign V   = head_q[0] & OUT_VLD;
    assign CNT = cnt_q;

`ifdef ENC_ONEHOT_CHK_EN
    logic err_q, err_d;
    logic multi_hot;

    assign multi_hot = (D3 & D2) | (D3 & D1) | (D3 & D0) |
                       (D2 & D1) | (D2 & D0) | (D1 & D0);

    always_comb begin
        err_d = err_q | (push & multi_hot);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_enc4x2_reg.sv
// ============================================================================
// tb_enc4x2_reg : randomized self-checking bench for enc4x2_reg
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_enc4x2_reg;

    logic       CLK;
    logic       RSTn;
    logic       D3, D2, D1, D0;
    logic       IN_VLD;
    logic       IN_RDY;
    logic       Y1, Y0, V;
    logic       OUT_VLD;
    logic       OUT_RDY;
    logic [7:0] CNT;
    logic       ERR;

    int checks;
    int errors;

    // Reference model: queue of {code[1:0], valid} in acceptance order
    bit [2:0] mq[$];
    int       m_cnt;
    bit       m_err;

    enc4x2_reg dut (
        .CLK(CLK), .RSTn(RSTn),
        .D3(D3), .D2(D2), .D1(D1), .D0(D0),
        .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
        .Y1(Y1), .Y0(Y0), .V(V),
        .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY),
        .CNT(CNT), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit [2:0] ref_enc(input bit [3:0] d);
        for (int i = 3; i >= 0; i--) begin
            if (d[i]) return {i[1:0], 1'b1};
        end
        return 3'b000;
    endfunction

    // Expected {OUT_VLD, IN_RDY, Y1, Y0, V, CNT, ERR}
    function automatic bit [13:0] exp_vec();
        bit [2:0] h;
        h = (mq.size() > 0) ? mq[0] : 3'b000;
        return {mq.size() > 0, mq.size() < 2, h, m_cnt[7:0], m_err};
    endfunction

    task automatic drive(input bit [3:0] d, input bit vld, input bit ordy);
        {D3, D2, D1, D0} = d;
        IN_VLD  = vld;
        OUT_RDY = ordy;
    endtask

    // Advance the model by the handshake seen at the coming edge, then the clock.
    task automatic tick();
        bit [3:0] d;
        bit       do_pop;
        bit       do_push;
        d = {D3, D2, D1, D0};
        if (RSTn) begin
            do_pop  = (mq.size() > 0) && OUT_RDY;
            do_push = IN_VLD && (mq.size() < 2);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(ref_enc(d));
                m_cnt = (m_cnt + 1) % 256;
`ifdef ENC_ONEHOT_CHK_EN
                if ($countones(d) >= 2) m_err = 1'b1;
`endif
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        mq.delete();
        m_cnt = 0;
        m_err = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({OUT_VLD, IN_RDY, Y1, Y0, V, CNT, ERR} !== {1'b0, 1'b1, 3'b000, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", {OUT_VLD, IN_RDY, Y1, Y0, V, CNT, ERR},
                     {1'b0, 1'b1, 3'b000, 8'd0, 1'b0});
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive(4'b0100, 1'b1, 1'b1);
        tick();
        checks++;
        if ({Y1, Y0, V, OUT_VLD, CNT} !== {2'b10, 1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL basic_0100 got %b exp %b", {Y1, Y0, V, OUT_VLD, CNT}, {2'b10, 1'b1, 1'b1, 8'd1});
        end
        drive(4'b0000, 1'b0, 1'b1);
        tick();
        checks++;
        if ({OUT_VLD, Y1, Y0, V} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_drain got %b exp %b", {OUT_VLD, Y1, Y0, V}, 4'b0000);
        end
    endtask

    task automatic test_full();
        do_reset();
        drive(4'b0001, 1'b1, 1'b0);
        tick();
        drive(4'b1000, 1'b1, 1'b0);
        tick();
        checks++;
        if ({IN_RDY, OUT_VLD, Y1, Y0, V, CNT} !== {1'b0, 1'b1, 2'b00, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL full_state got %b exp %b", {IN_RDY, OUT_VLD, Y1, Y0, V, CNT},
                     {1'b0, 1'b1, 2'b00, 1'b1, 8'd2});
        end
        drive(4'b0100, 1'b1, 1'b0);
        tick();
        checks++;
        if ({IN_RDY, Y1, Y0, V, CNT} !== {1'b0, 2'b00, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL full_ignore got %b exp %b", {IN_RDY, Y1, Y0, V, CNT}, {1'b0, 2'b00, 1'b1, 8'd2});
        end
        drive(4'b0000, 1'b0, 1'b1);
        tick();
        checks++;
        if ({OUT_VLD, Y1, Y0, V, IN_RDY} !== {1'b1, 2'b11, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL full_pop1 got %b exp %b", {OUT_VLD, Y1, Y0, V, IN_RDY}, {1'b1, 2'b11, 1'b1, 1'b1});
        end
        tick();
        checks++;
        if ({OUT_VLD, Y1, Y0, V} !== 4'b0000) begin
            errors++;
            $display("FAIL full_pop2 got %b exp %b", {OUT_VLD, Y1, Y0, V}, 4'b0000);
        end
    endtask

    task automatic test_zero();
        do_reset();
        drive(4'b0000, 1'b1, 1'b0);
        tick();
        checks++;
        if ({OUT_VLD, Y1, Y0, V} !== 4'b1000) begin
            errors++;
            $display("FAIL zero_input got %b exp %b", {OUT_VLD, Y1, Y0, V}, 4'b1000);
        end
        drive(4'b0001, 1'b1, 1'b1);
        tick();
        checks++;
        if ({OUT_VLD, Y1, Y0, V} !== 4'b1001) begin
            errors++;
            $display("FAIL d0_input got %b exp %b", {OUT_VLD, Y1, Y0, V}, 4'b1001);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        drive(4'b1000, 1'b1, 1'b0);
        tick();
        drive(4'b0010, 1'b1, 1'b1);
        tick();
        checks++;
        if ({OUT_VLD, IN_RDY, Y1, Y0, V, CNT} !== {1'b1, 1'b1, 2'b01, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL push_pop got %b exp %b", {OUT_VLD, IN_RDY, Y1, Y0, V, CNT},
                     {1'b1, 1'b1, 2'b01, 1'b1, 8'd2});
        end
    endtask

    task automatic test_err();
        bit exp_err;
`ifdef ENC_ONEHOT_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        drive(4'b1010, 1'b1, 1'b1);
        tick();
        checks++;
        if ({Y1, Y0, V, ERR} !== {2'b11, 1'b1, exp_err}) begin
            errors++;
            $display("FAIL err_set got %b exp %b", {Y1, Y0, V, ERR}, {2'b11, 1'b1, exp_err});
        end
        drive(4'b0001, 1'b1, 1'b1);
        tick();
        tick();
        checks++;
        if ({Y1, Y0, V, ERR} !== {2'b00, 1'b1, exp_err}) begin
            errors++;
            $display("FAIL err_sticky got %b exp %b", {Y1, Y0, V, ERR}, {2'b00, 1'b1, exp_err});
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(4'($urandom_range(0, 15)), 1'b1, 1'b1);
            tick();
        end
        checks++;
        if ({CNT, OUT_VLD} !== {8'd0, 1'b1}) begin
            errors++;
            $display("FAIL cnt_wrap got %b exp %b", {CNT, OUT_VLD}, {8'd0, 1'b1});
        end
        drive(4'b0010, 1'b1, 1'b0);
        tick();
        checks++;
        if ({OUT_VLD, IN_RDY} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_full got %b exp %b", {OUT_VLD, IN_RDY}, 2'b10);
        end
        #2;
        RSTn = 1'b0;
        #1;
        checks++;
        if ({OUT_VLD, IN_RDY, Y1, Y0, V, CNT, ERR} !== {1'b0, 1'b1, 3'b000, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", {OUT_VLD, IN_RDY, Y1, Y0, V, CNT, ERR},
                     {1'b0, 1'b1, 3'b000, 8'd0, 1'b0});
        end
        do_reset();
    endtask

    task automatic test_random();
        bit [13:0] act;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0));
            tick();
            act = {OUT_VLD, IN_RDY, Y1, Y0, V, CNT, ERR};
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle_%0d got %b exp %b", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
        RSTn   = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        #1;
        test_reset();
        test_basic();
        test_full();
        test_zero();
        test_push_pop();
        test_err();
        test_wrap_and_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/enc4x2_reg.md
ENC4X2_REG -- requirements
Module: enc4x2_reg

Interface
REQ-001 SHALL have ports: CLK  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: RSTn  input  1  asynchronous active-low reset.
REQ-003 SHALL have: D3, D2, D1, D0  input  1 each  request lines to encode; D3 highest priority.
REQ-004 SHALL have: IN_VLD  input  1  request lines valid this cycle.
REQ-005 SHALL have: IN_RDY  output  1  block can accept a sample (buffer not full).
REQ-006 SHALL have: Y1, Y0  output  1 each  encoded index of the head entry.
REQ-007 SHALL have: V  output  1  head entry had at least one request line set.
REQ-008 SHALL have: OUT_VLD  output  1  head entry present.
REQ-009 SHALL have: OUT_RDY  input  1  consumer accepts the head entry.
REQ-010 SHALL have: CNT  output  8  count of accepted samples, modulo 256.
REQ-011 SHALL have: ERR  output  1  sticky multi-hot flag (see Configuration).

Function
REQ-012 Accept: sample taken on the rising edge where IN_VLD=1 and IN_RDY=1; otherwise the inputs are ignored.
REQ-013 Encode: D3 set -> 11; else D2 -> 10; else D1 -> 01; else D0 -> 00. V=1 if any line set; all zero -> code 00, V=0.
REQ-014 Buffer: 2-entry FIFO of {Y1,Y0,V}; states EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
REQ-015 Latency: an entry accepted at edge N into EMPTY appears on Y1/Y0/V with OUT_VLD=1 immediately after edge N.
REQ-016 Pop: head removed on the rising edge where OUT_VLD=1 and OUT_RDY=1.
REQ-017 IN_RDY = 1 in EMPTY and ONE, 0 in FULL; IN_RDY SHALL NOT depend combinationally on OUT_RDY.
REQ-018 OUT_VLD = 1 in ONE and FULL; Y1/Y0/V SHALL be stable while OUT_VLD=1 and OUT_RDY=0.
REQ-019 Transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE, new entry becomes head; FULL+pop -> ONE; otherwise hold.
REQ-020 When OUT_VLD=0, Y1, Y0 and V SHALL be 0.
REQ-021 CNT SHALL increment by 1 on every accepted sample and wrap from 255 to 0.
REQ-022 Entries SHALL leave in acceptance order; no entry is dropped or duplicated.

Reset
REQ-023 RSTn=0 SHALL asynchronously force state EMPTY, Y1=Y0=V=0, OUT_VLD=0, IN_RDY=1, CNT=0, ERR=0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered entries; no accept or pop occurs while RSTn=0.
REQ-025 First accept possible on the first rising edge after RSTn deasserts.

Configuration
REQ-026 Macro ENC_ONEHOT_CHK_EN defined: ERR SHALL set on an accepted sample with two or more of D3..D0 high and hold at 1 until reset; encoding unaffected.
REQ-027 Macro ENC_ONEHOT_CHK_EN undefined: ERR SHALL be constant 0 and the check logic absent.

Verification
REQ-028 Reset, then accept D3..D0=0100 with OUT_RDY=1 -> next cycle Y1Y0=10, V=1, OUT_VLD=1, CNT=1.
REQ-029 OUT_RDY=0, accept 0001 then 1000 -> FULL, IN_RDY=0, head 00/V=1 held; third IN_VLD ignored, CNT=2; raise OUT_RDY -> outputs 00 then 11, then OUT_VLD=0.
REQ-030 Accept 0000 -> Y1Y0=00, V=0, OUT_VLD=1; distinguishable from input 0001 (V=1).
REQ-031 In ONE, push 0010 and pop same edge -> stays ONE, head becomes 01, CNT +1.
REQ-032 With ENC_ONEHOT_CHK_EN, accept 1010 -> Y1Y0=11, ERR=1, ERR stays 1 after later 0001; without macro ERR=0 throughout.
REQ-033 256 consecutive accepts -> CNT wraps to 0; assert RSTn=0 while FULL -> OUT_VLD=0, IN_RDY=1 immediately, without a clock edge.
